// File: rtl/soc_int_pkg.sv
// rtl/soc_int_pkg.sv - shared types for the interrupt router and its per-source channels
package soc_int_pkg;

    typedef enum logic [1:0] {
        INT_LEVEL = 2'd0,
        INT_RISE  = 2'd1,
        INT_FALL  = 2'd2,
        INT_BOTH  = 2'd3
    } int_mode_t;

    // Field order matches the cfg_wdata/cfg_rdata byte: [7:3] target, [2:1] mode, [0] enable.
    typedef struct packed {
        logic [4:0] target;
        int_mode_t  mode;
        logic       enable;
    } int_cfg_t;

    localparam int_cfg_t INT_CFG_RESET = '{target: 5'd0, mode: INT_LEVEL, enable: 1'b0};

endpackage

// File: rtl/soc_int_channel.sv
// rtl/soc_int_channel.sv - one interrupt source: synchroniser, edge history, mode decode, pending flop
module soc_int_channel
    import soc_int_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      res_n,
    input  logic      src,
    input  int_mode_t mode,
    input  logic      clr,
    input  logic      cfg_load,
    output logic      pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   set_evt;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        set_evt = 1'b0;
        case (mode)
            INT_RISE: set_evt = s_sync & ~s_prev;
            INT_FALL: set_evt = ~s_sync & s_prev;
            INT_BOTH: set_evt = s_sync ^ s_prev;
            default:  set_evt = 1'b0;
        endcase
    end

    // s_prev always tracks s_sync, so a config reload naturally re-bases the edge history.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync_q  <= '0;
            s_prev  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s_sync;
            if (cfg_load) begin
                pending <= 1'b0;
            end else if (mode == INT_LEVEL) begin
                pending <= s_sync;
            end else if (set_evt) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/soc_int_router.sv
// rtl/soc_int_router.sv - interrupt router top: config store, per-source channels, trigger OR-routing
// Optional SOC_INT_ROUTER_PRIO_EN adds the top_valid/top_id priority encoder outputs.
module soc_int_router
    import soc_int_pkg::*;
#(
    parameter int SOURCE_COUNT  = 16,
    parameter int TRIGGER_COUNT = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SRC_IDX_W     = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [SOURCE_COUNT-1:0]  src_in,
    input  logic                     cfg_we,
    input  logic [SRC_IDX_W-1:0]     cfg_sel,
    input  logic [7:0]               cfg_wdata,
    output logic [7:0]               cfg_rdata,
    input  logic                     clr_we,
    input  logic [SRC_IDX_W-1:0]     clr_sel,
    output logic [SOURCE_COUNT-1:0]  pending,
    output logic [TRIGGER_COUNT-1:0] int_triggers
`ifdef SOC_INT_ROUTER_PRIO_EN
    ,
    output logic                     top_valid,
    output logic [SRC_IDX_W-1:0]     top_id
`endif
);

    int_cfg_t                 cfg_q [SOURCE_COUNT];
    logic                     cfg_sel_ok;
    logic [SOURCE_COUNT-1:0]  active;
    logic [TRIGGER_COUNT-1:0] trig_next;

    assign cfg_sel_ok = 32'(cfg_sel) < 32'(SOURCE_COUNT);
    assign cfg_rdata  = cfg_sel_ok ? cfg_q[cfg_sel] : 8'h00;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < SOURCE_COUNT; i++) begin
                cfg_q[i] <= INT_CFG_RESET;
            end
        end else if (cfg_we && cfg_sel_ok) begin
            cfg_q[cfg_sel] <= int_cfg_t'(cfg_wdata);
        end
    end

    for (genvar g = 0; g < SOURCE_COUNT; g++) begin : g_ch
        soc_int_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .res_n    (res_n),
            .src      (src_in[g]),
            .mode     (cfg_q[g].mode),
            .clr      (clr_we && (clr_sel == SRC_IDX_W'(g))),
            .cfg_load (cfg_we && (cfg_sel == SRC_IDX_W'(g))),
            .pending  (pending[g])
        );
        assign active[g] = pending[g] & cfg_q[g].enable;
    end

    // Targets at or beyond TRIGGER_COUNT simply match no output bit.
    always_comb begin
        trig_next = '0;
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            for (int t = 0; t < TRIGGER_COUNT; t++) begin
                if (active[i] && (32'(cfg_q[i].target) == 32'(t))) begin
                    trig_next[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            int_triggers <= '0;
        end else begin
            int_triggers <= trig_next;
        end
    end

`ifdef SOC_INT_ROUTER_PRIO_EN
    logic [SRC_IDX_W-1:0] top_id_next;

    always_comb begin
        top_id_next = '0;
        for (int i = SOURCE_COUNT - 1; i >= 0; i--) begin
            if (active[i]) begin
                top_id_next = SRC_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            top_valid <= 1'b0;
            top_id    <= '0;
        end else begin
            top_valid <= |active;
            top_id    <= top_id_next;
        end
    end
`endif

endmodule

// File: tb/tb_soc_int_router.sv
// tb/tb_soc_int_router.sv - directed self-checking bench for soc_int_router
module tb_soc_int_router;

    localparam int SRC_N  = 12;
    localparam int TRIG_N = 16;
    localparam int IDX_W  = 4;

    localparam logic [1:0] M_LEVEL = 2'd0;
    localparam logic [1:0] M_RISE  = 2'd1;
    localparam logic [1:0] M_FALL  = 2'd2;
    localparam logic [1:0] M_BOTH  = 2'd3;

    logic              clk = 1'b0;
    logic              res_n;
    logic [SRC_N-1:0]  src_in;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_sel;
    logic [7:0]        cfg_wdata;
    logic [7:0]        cfg_rdata;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_sel;
    logic [SRC_N-1:0]  pending;
    logic [TRIG_N-1:0] int_triggers;
`ifdef SOC_INT_ROUTER_PRIO_EN
    logic              top_valid;
    logic [IDX_W-1:0]  top_id;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_int_router #(
        .SOURCE_COUNT  (SRC_N),
        .TRIGGER_COUNT (TRIG_N),
        .SYNC_STAGES   (2)
    ) dut (
        .clk          (clk),
        .res_n        (res_n),
        .src_in       (src_in),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .clr_we       (clr_we),
        .clr_sel      (clr_sel),
        .pending      (pending),
        .int_triggers (int_triggers)
`ifdef SOC_INT_ROUTER_PRIO_EN
        ,
        .top_valid    (top_valid),
        .top_id       (top_id)
`endif
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [3:0] sel, input logic en, input logic [1:0] mode,
                             input logic [4:0] tgt);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_wdata = {tgt, mode, en};
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic clear_src(input logic [3:0] sel);
        clr_we  = 1'b1;
        clr_sel = sel;
        tick(1);
        clr_we  = 1'b0;
    endtask

    initial begin
        res_n     = 1'b0;
        src_in    = '0;
        cfg_we    = 1'b0;
        cfg_sel   = '0;
        cfg_wdata = '0;
        clr_we    = 1'b0;
        clr_sel   = '0;
        tick(3);
        res_n = 1'b1;
        tick(3);

        check("reset_pending", 32'(pending), 32'h0);
        check("reset_triggers", 32'(int_triggers), 32'h0);
        for (int s = 0; s < 16; s++) begin
            cfg_sel = 4'(s);
            #1;
            check($sformatf("reset_rdata_%0d", s), 32'(cfg_rdata), 32'h0);
        end

        // src 3 RISE, enabled, target 5
        write_cfg(4'd3, 1'b1, M_RISE, 5'd5);
        cfg_sel = 4'd3;
        #1;
        check("rdata_src3", 32'(cfg_rdata), 32'h2B);
        src_in[3] = 1'b1;
        tick(3);
        check("rise_pending_edge3", 32'(pending[3]), 32'h1);
        check("rise_trig_edge3", 32'(int_triggers), 32'h0);
        tick(1);
        check("rise_trig_edge4", 32'(int_triggers), 32'h20);
        src_in[3] = 1'b0;
        tick(4);
        check("rise_sticky", 32'(int_triggers), 32'h20);
        clear_src(4'd3);
        check("rise_clr_pending", 32'(pending[3]), 32'h0);
        check("rise_clr_trig_lag", 32'(int_triggers), 32'h20);
        tick(1);
        check("rise_clr_trig", 32'(int_triggers), 32'h0);

        // src 0 LEVEL target 8: clear ignored while level high
        write_cfg(4'd0, 1'b1, M_LEVEL, 5'd8);
        src_in[0] = 1'b1;
        tick(4);
        check("level_trig_on", 32'(int_triggers), 32'h100);
        clear_src(4'd0);
        check("level_clr_ignored", 32'(pending[0]), 32'h1);
        tick(1);
        check("level_trig_hold", 32'(int_triggers), 32'h100);
        src_in[0] = 1'b0;
        tick(3);
        check("level_trig_edge3", 32'(int_triggers), 32'h100);
        tick(1);
        check("level_trig_edge4", 32'(int_triggers), 32'h0);

        // srcs 1 and 2 share target 4, BOTH mode
        write_cfg(4'd1, 1'b1, M_BOTH, 5'd4);
        write_cfg(4'd2, 1'b1, M_BOTH, 5'd4);
        src_in[1] = 1'b1;
        tick(4);
        check("both_trig_shared", 32'(int_triggers), 32'h10);
        check("both_pending", 32'(pending[2:1]), 32'h1);
        src_in[1] = 1'b0;
        tick(2);
        clear_src(4'd1);
        check("set_beats_clear", 32'(pending[1]), 32'h1);
        clear_src(4'd1);
        check("both_clear", 32'(pending[1]), 32'h0);
        tick(1);
        check("both_trig_off", 32'(int_triggers), 32'h0);

        // src 6: reconfigure while input high must not create an edge
        write_cfg(4'd6, 1'b1, M_RISE, 5'd2);
        src_in[6] = 1'b1;
        tick(4);
        check("src6_rise", 32'(pending[6]), 32'h1);
        clear_src(4'd6);
        check("src6_clr", 32'(pending[6]), 32'h0);
        write_cfg(4'd6, 1'b1, M_FALL, 5'd2);
        tick(3);
        check("src6_no_spurious", 32'(pending[6]), 32'h0);
        src_in[6] = 1'b0;
        tick(3);
        check("src6_fall", 32'(pending[6]), 32'h1);
        tick(1);
        check("src6_trig", 32'(int_triggers), 32'h4);

        // out-of-range sel: write ignored, read zero, clear ignored
        write_cfg(4'd13, 1'b1, M_RISE, 5'd3);
        cfg_sel = 4'd13;
        #1;
        check("oor_rdata", 32'(cfg_rdata), 32'h0);
        clear_src(4'd14);
        check("oor_clr", 32'(pending), 32'h040);

        // target beyond TRIGGER_COUNT: stored intact, routes nowhere
        write_cfg(4'd7, 1'b1, M_RISE, 5'd20);
        cfg_sel = 4'd7;
        #1;
        check("tgt20_rdata", 32'(cfg_rdata), 32'hA3);
        src_in[7] = 1'b1;
        tick(4);
        check("tgt20_pending", 32'(pending[7]), 32'h1);
        check("tgt20_trig", 32'(int_triggers), 32'h4);
        write_cfg(4'd7, 1'b1, M_RISE, 5'd20);
        check("cfg_write_clears", 32'(pending[7]), 32'h0);

        // disabled source still pends but does not route
        write_cfg(4'd8, 1'b0, M_LEVEL, 5'd9);
        src_in[8] = 1'b1;
        tick(4);
        check("disabled_pending", 32'(pending[8]), 32'h1);
        check("disabled_trig", 32'(int_triggers), 32'h4);

`ifdef SOC_INT_ROUTER_PRIO_EN
        src_in = '0;
        res_n  = 1'b0;
        tick(1);
        res_n = 1'b1;
        tick(1);
        write_cfg(4'd9, 1'b1, M_RISE, 5'd0);
        write_cfg(4'd4, 1'b1, M_RISE, 5'd1);
        src_in[9] = 1'b1;
        src_in[4] = 1'b1;
        tick(4);
        check("prio_valid", 32'(top_valid), 32'h1);
        check("prio_id_4", 32'(top_id), 32'h4);
        clear_src(4'd4);
        tick(1);
        check("prio_id_9", 32'(top_id), 32'h9);
        clear_src(4'd9);
        tick(1);
        check("prio_none_valid", 32'(top_valid), 32'h0);
        check("prio_none_id", 32'(top_id), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_int_router.md
Name: soc_int_router

Overview:
- Parametrised interrupt routing block. It is the successor to the fixed, hard-wired trigger concatenation used in the peripheral section.
- Takes SOURCE_COUNT raw interrupt sources from peripherals and core, synchronises them, and applies per-source mode (level/edge), enable and pending latching.
- Routes each source to a runtime-selectable bit of the SoC trigger vector consumed by soc_control.
- Sits between peripheral trigger outputs and soc_control.int_triggers.

Parameters:
- SOURCE_COUNT, 16, number of interrupt sources (1..64)
- TRIGGER_COUNT, 32, width of routed trigger vector (1..32)
- SYNC_STAGES, 2, synchroniser flops per source (>=1)
- SRC_IDX_W, $clog2(SOURCE_COUNT) (min 1), derived source index width; not to be overridden

Ports:
- clk  input  1  system clock
- res_n  input  1  asynchronous active-low reset
- src_in  input  SOURCE_COUNT  raw interrupt sources, asynchronous to clk allowed
- cfg_we  input  1  config write strobe
- cfg_sel  input  SRC_IDX_W  source index for config read/write
- cfg_wdata  input  8  [0]=enable, [2:1]=mode, [7:3]=target trigger index
- cfg_rdata  output  8  config of source cfg_sel, combinational read
- clr_we  input  1  pending clear strobe
- clr_sel  input  SRC_IDX_W  source whose pending bit is cleared
- pending  output  SOURCE_COUNT  registered pending bits
- int_triggers  output  TRIGGER_COUNT  registered routed trigger vector

Behaviour:
- Reset (res_n low, asynchronous):
  - pending=0, int_triggers=0.
  - All configs = 0 (disabled, mode LEVEL, target 0).
  - Synchroniser flops and edge-history flops = 0.
- Per source, a SYNC_STAGES flop chain produces s_sync. A one-flop history s_prev holds the previous s_sync.
- Modes:
  - 0 LEVEL: pending <= s_sync each cycle. Clear is ignored while the level stays high.
  - 1 RISE: set on s_sync & ~s_prev.
  - 2 FALL: set on ~s_sync & s_prev.
  - 3 BOTH: set on s_sync ^ s_prev.
  - Edge-mode pending is sticky until cleared.
- Pending sets regardless of enable; enable gates routing only.
- Routing: int_triggers[t] <= OR over i of (pending[i] & enable[i] & target[i]==t).
  - Target >= TRIGGER_COUNT routes nowhere; this is legal, not an error.
  - Several sources may share one target (wired-OR).
- Latency: a src_in transition stable before clock edge 1 is in s_sync after edge SYNC_STAGES, in pending after edge SYNC_STAGES+1, and in int_triggers after edge SYNC_STAGES+2.
- Clear:
  - clr_we clears pending[clr_sel] at the next edge.
  - Set and clear of the same source in the same cycle: set wins.
  - clr_sel >= SOURCE_COUNT is ignored.
- Config write:
  - cfg_we updates config[cfg_sel] at the next edge.
  - On that edge, pending[cfg_sel] is cleared and s_prev[cfg_sel] is loaded with s_sync, so a mode change cannot fire a spurious edge. Any set event in that same cycle is discarded.
  - cfg_sel >= SOURCE_COUNT: write ignored, rdata = 0.
- cfg_we and clr_we in the same cycle are independent; both take effect.
- Upper target bits beyond those needed for TRIGGER_COUNT are stored and read back unchanged.

Optional Feature:
- Macro SOC_INT_ROUTER_PRIO_EN.
- With the macro, two extra outputs:
  - top_valid (1): registered, same edge as int_triggers; 1 if any enabled pending source exists.
  - top_id (SRC_IDX_W): registered, same edge as int_triggers; lowest-indexed enabled pending source, 0 when none.
- Without the macro, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package soc_int_pkg:
  - int_mode_t enum (INT_LEVEL, INT_RISE, INT_FALL, INT_BOTH)
  - int_cfg_t packed struct {target[4:0], mode, enable}, matching the cfg_wdata layout
  - INT_CFG_RESET constant
- Sub-module soc_int_channel, one per source via generate: synchroniser, s_prev, mode decode, pending flop; inputs clr and cfg_load.
- Routing OR-reduction, priority encoder and config storage live in the top.

Test Plan:
- Reset release, all src_in=0, no config -> pending=0, int_triggers=0, cfg_rdata=0 for every sel.
- Src 3 mode RISE, enable, target 5; pulse src_in[3] 0->1 -> int_triggers[5]=1 exactly SYNC_STAGES+2 edges after; it stays 1 after src falls; clr_sel=3 -> int_triggers[5]=0 one edge after pending clears.
- Src 0 LEVEL target 8; hold src_in[0]=1 and assert clr -> pending[0] stays 1. Release src -> int_triggers[8] drops SYNC_STAGES+2 edges later.
- Srcs 1 and 2 both target 4, each BOTH mode; toggle src 1 only -> int_triggers[4]=1. Clear src 1 on the same cycle as a new src 1 edge -> pending[1] remains 1.
- Src 6 RISE with src_in[6] high; rewrite config to FALL -> no spurious pending. Drive src low -> pending[6]=1.
- PRIO_EN build: pending on srcs 9 and 4, both enabled -> top_id=4, top_valid=1. Clear 4 -> top_id=9. Clear 9 -> top_valid=0, top_id=0.
